// File: rtl/div_sequencer_if.sv
// Divider sequencer bus.
// Groups the issue, hazard and writeback signals that pass between the pipeline
// and div_sequencer. Clock and reset stay outside the interface as plain ports.
//   master : pipeline side. Drives Start, Op, Dividend, Divisor, Rd, Rs1, Rs2 and Wb_Ack;
//            observes Busy, Done, Result, Wb_Rd and Div_Stall.
//   slave  : divider side, with the opposite directions.
interface div_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] Dividend;
  logic [DATA_WIDTH-1:0] Divisor;
  logic [REG_WIDTH-1:0]  Rd;
  logic [REG_WIDTH-1:0]  Rs1;
  logic [REG_WIDTH-1:0]  Rs2;
  logic                  Wb_Ack;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Result;
  logic [REG_WIDTH-1:0]  Wb_Rd;
  logic                  Div_Stall;

  modport master (
    output Start, Op, Dividend, Divisor, Rd, Rs1, Rs2, Wb_Ack,
    input  Busy, Done, Result, Wb_Rd, Div_Stall
  );

  modport slave (
    input  Start, Op, Dividend, Divisor, Rd, Rs1, Rs2, Wb_Ack,
    output Busy, Done, Result, Wb_Rd, Div_Stall
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU/REM/REMU.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset; aborts any divide in progress
//   bus  - div_sequencer_if.slave:
//            Start/Op/Dividend/Divisor/Rd  issue a divide. They are only sampled in IDLE.
//            Rs1/Rs2                       sources of the instruction in decode, used for RAW stall.
//            Wb_Ack                        writeback grant. It only has an effect while Done is high.
//            Busy/Done/Result/Wb_Rd        status and the result to be written back.
//            Div_Stall                     structural or RAW stall request.
// State flow: IDLE -> CHECK -> CALC (DATA_WIDTH cycles) -> FIX -> DONE -> IDLE.
// Optional macro DIV_FAST_PATH_EN: a zero divisor or signed overflow skips CALC/FIX.
// In that case the flow goes CHECK -> DONE directly.
module div_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);

  localparam logic [5:0] LastIter = 6'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;       // raw latched dividend
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;       // raw latched divisor
  logic [DATA_WIDTH-1:0] mag_q, mag_d;       // divisor magnitude used by CALC
  logic [DATA_WIDTH-1:0] quo_q, quo_d;       // dividend shifts out while quotient bits shift in
  logic [DATA_WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [REG_WIDTH-1:0]  rd_q, rd_d;
  logic [5:0]            cnt_q, cnt_d;

  logic                  op_signed;
  logic                  op_rem;
  logic                  dvd_neg;
  logic                  dvs_neg;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] q_fixed;
  logic [DATA_WIDTH-1:0] r_fixed;

  // Op[0] selects unsigned and Op[1] selects remainder.
  assign op_signed = ~op_q[0];
  assign op_rem    = op_q[1];
  assign dvd_neg   = op_signed & dvd_q[DATA_WIDTH-1];
  assign dvs_neg   = op_signed & dvs_q[DATA_WIDTH-1];

  // One restoring step. A non-negative diff (top bit clear) means the subtract is kept.
  assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff      = rem_shift - {1'b0, mag_q};

  // A zero divisor leaves the quotient all-ones unsigned, so no negation is applied.
  // The remainder is then |dividend|, and the sign restore turns it back into the dividend.
  assign q_fixed = ((dvd_neg ^ dvs_neg) && (dvs_q != '0)) ? -quo_q : quo_q;
  assign r_fixed = dvd_neg ? -rem_q : rem_q;

`ifdef DIV_FAST_PATH_EN
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic div_zero;
  logic sgn_ovf;

  assign div_zero = (dvs_q == '0);
  assign sgn_ovf  = op_signed && (dvd_q == MinVal) && (dvs_q == '1);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    mag_d    = mag_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;

    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          op_d    = bus.Op;
          dvd_d   = bus.Dividend;
          dvs_d   = bus.Divisor;
          rd_d    = bus.Rd;
          state_d = StCheck;
        end
      end

      StCheck: begin
        quo_d   = dvd_neg ? -dvd_q : dvd_q;
        mag_d   = dvs_neg ? -dvs_q : dvs_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = StCalc;
`ifdef DIV_FAST_PATH_EN
        if (div_zero) begin
          result_d = op_rem ? dvd_q : '1;
          state_d  = StDone;
        end else if (sgn_ovf) begin
          result_d = op_rem ? '0 : MinVal;
          state_d  = StDone;
        end
`endif
      end

      StCalc: begin
        if (!diff[DATA_WIDTH]) begin
          rem_d = diff[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end

      StFix: begin
        result_d = op_rem ? r_fixed : q_fixed;
        state_d  = StDone;
      end

      StDone: begin
        if (bus.Wb_Ack) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      mag_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      mag_q    <= mag_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Busy   = (state_q != StIdle);
  assign bus.Done   = (state_q == StDone);
  assign bus.Result = result_q;
  assign bus.Wb_Rd  = rd_q;

  // x0 is never a real hazard, so Rd==0 does not raise the RAW stall.
  assign bus.Div_Stall = bus.Busy &
                         (bus.Start |
                          ((rd_q != '0) && ((rd_q == bus.Rs1) || (rd_q == bus.Rs2))));

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam logic [31:0] MinVal = 32'h8000_0000;
`ifdef DIV_FAST_PATH_EN
  localparam bit FastPath = 1'b1;
`else
  localparam bit FastPath = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) bus ();

  div_sequencer #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written as plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MinVal) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? MinVal : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && a == MinVal && b == 32'hFFFF_FFFF);
    return (FastPath && special) ? 2 : 35;
  endfunction

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Scoreboard monitor: a result is consumed on the cycle its writeback is granted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Done && bus.Wb_Ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.Result, e.res);
          check("wb_rd", 32'(bus.Wb_Rd), 32'(e.rd));
        end
      end
    end
  end

  // Caller is in the drive phase (just after a rising edge) with the divider idle.
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input int hold, input bit tie_ack);
    int          edges;
    int          stall_bad;
    bit          raw;
    logic [31:0] cap_res;
    logic [4:0]  cap_rd;
    check("idle_before_issue", 32'(bus.Busy), 32'd0);
    exp_q.push_back('{res: ref_result(op, a, b), rd: rd});
    raw          = (rd != 0) && (rd == rs1 || rd == rs2);
    bus.Start    = 1'b1;
    bus.Op       = op;
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Rd       = rd;
    bus.Rs1      = rs1;
    bus.Rs2      = rs2;
    bus.Wb_Ack   = tie_ack;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    edges     = 1;
    stall_bad = 0;
    forever begin
      @(negedge clk);
      if (bus.Div_Stall !== raw) stall_bad++;
      if (bus.Done) break;
      if (edges >= 60) begin
        $display("FAIL done_timeout actual=no_done expected=done_by_edge_%0d",
                 ref_latency(op, a, b));
        errors++;
        checks++;
        finish_now();
      end
      @(posedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(ref_latency(op, a, b)));
    check("raw_stall_bad_cycles", 32'(stall_bad), 32'd0);
    cap_res = bus.Result;
    cap_rd  = bus.Wb_Rd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        // A second divide offered while DONE must be stalled and ignored.
        bus.Start    = 1'b1;
        bus.Op       = ~op;
        bus.Dividend = $urandom;
        bus.Divisor  = $urandom;
        bus.Rd       = rd + 5'd1;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      check("hold_done", 32'(bus.Done), 32'd1);
      check("hold_result", bus.Result, cap_res);
      check("hold_wb_rd", 32'(bus.Wb_Rd), 32'(cap_rd));
      check("hold_stall", 32'(bus.Div_Stall), 32'(bus.Start | raw));
    end
    if (!tie_ack) begin
      @(posedge clk);
      #1;
      bus.Start  = 1'b0;
      bus.Wb_Ack = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.Wb_Ack = 1'b0;
    check("idle_after_ack_busy", 32'(bus.Busy), 32'd0);
    check("idle_after_ack_done", 32'(bus.Done), 32'd0);
    check("idle_after_ack_stall", 32'(bus.Div_Stall), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    int          hold;
    bit          tie;

    rst          = 1'b1;
    bus.Start    = 1'b1;
    bus.Op       = 2'b01;
    bus.Dividend = 32'd50;
    bus.Divisor  = 32'd5;
    bus.Rd       = 5'd4;
    bus.Rs1      = 5'd4;
    bus.Rs2      = 5'd0;
    bus.Wb_Ack   = 1'b0;
    #12;
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_stall", 32'(bus.Div_Stall), 32'd0);
    check("reset_result", bus.Result, 32'd0);
    check("reset_wb_rd", 32'(bus.Wb_Rd), 32'd0);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    run_div(2'b01, 32'd100, 32'd7, 5'd5, 5'd1, 5'd2, 0, 1'b1);
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b00, 32'd5, 32'd0, 5'd7, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b10, 32'd5, 32'd0, 5'd7, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b00, MinVal, 32'hFFFF_FFFF, 5'd8, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b10, MinVal, 32'hFFFF_FFFF, 5'd8, 5'd0, 5'd0, 0, 1'b0);
    run_div(2'b01, 32'd1000, 32'd3, 5'd3, 5'd9, 5'd3, 0, 1'b0);
    run_div(2'b01, 32'd1000, 32'd3, 5'd0, 5'd0, 5'd4, 0, 1'b0);
    run_div(2'b11, 32'hDEAD_BEEF, 32'd1234, 5'd10, 5'd11, 5'd12, 10, 1'b0);

    // Reset during CALC iteration 12 aborts the divide.
    bus.Start    = 1'b1;
    bus.Op       = 2'b01;
    bus.Dividend = 32'd12345;
    bus.Divisor  = 32'd7;
    bus.Rd       = 5'd13;
    bus.Rs1      = 5'd13;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (13) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_stall", 32'(bus.Div_Stall), 32'd0);
    check("abort_result", bus.Result, 32'd0);
    check("abort_wb_rd", 32'(bus.Wb_Rd), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_div(2'b01, 32'd9, 32'd3, 5'd14, 5'd0, 5'd0, 0, 1'b0);

    // Randomized divides.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = MinVal; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      rd   = 5'($urandom);
      rs1  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      rs2  = 5'($urandom);
      hold = $urandom_range(0, 4);
      tie  = (hold == 0) && ($urandom_range(0, 1) == 1);
      run_div(op, a, b, rd, rs1, rs2, hold, tie);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    finish_now();
  end

endmodule
